// File: rtl/alu_seq.sv
// Multi-word ADD/SUB/AND/OR sequencer driving one shared N-bit ALU, LS word first.
// Optional: define ALU_SEQ_SIGNED_EN to build signed-overflow detection on ovf_flag.
module alu_seq #(
  parameter int unsigned N      = 8,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned AC_N   = 3,
  parameter int unsigned CS_AD  = 0,
  parameter int unsigned CS_SB  = 1,
  parameter int unsigned CS_ADX = 2,
  parameter int unsigned CS_SBX = 3,
  parameter int unsigned CS_AN  = 4,
  parameter int unsigned CS_OR  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WORDS*N-1:0]   a_in,
  input  logic [WORDS*N-1:0]   b_in,
  output logic                 busy,
  output logic                 done,
  output logic [WORDS*N-1:0]   result,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 ovf_flag,
  output logic [AC_N-1:0]      alu_cs,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic                 alu_cin,
  input  logic [N-1:0]         alu_s,
  input  logic                 alu_zero,
  input  logic                 alu_cout
);

  localparam int unsigned W    = WORDS * N;
  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] OpAdd = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpAnd = 2'b10;
  localparam logic [1:0] OpOr  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]      op_q, op_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            c_q, c_d, zacc_q, zacc_d, carry_q, carry_d, zero_q, zero_d;
  logic            last_word, arith;
  logic [31:0]     base;

  assign base      = 32'(idx_q) * N;
  assign last_word = (idx_q == IdxW'(WORDS - 1));
  assign arith     = (op_q == OpAdd) || (op_q == OpSub);

  always_comb begin
    alu_cs  = AC_N'(CS_ADX);
    alu_a   = a_q[N-1:0];
    alu_b   = b_q[N-1:0];
    alu_cin = 1'b0;
    if (state_q == StRun) begin
      alu_a   = a_q[base +: N];
      alu_b   = b_q[base +: N];
      alu_cin = c_q;
      // First word ignores the chained carry; later words consume it.
      unique case (op_q)
        OpAdd: alu_cs = (idx_q == '0) ? AC_N'(CS_ADX) : AC_N'(CS_AD);
        OpSub: alu_cs = (idx_q == '0) ? AC_N'(CS_SBX) : AC_N'(CS_SB);
        OpAnd: alu_cs = AC_N'(CS_AN);
        OpOr:  alu_cs = AC_N'(CS_OR);
      endcase
    end
  end

`ifdef ALU_SEQ_SIGNED_EN
  logic ovf_q, ovf_d;
  logic sa, sb, ss;
  assign sa = a_q[W-1];
  assign sb = b_q[W-1];
  assign ss = alu_s[N-1];
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    idx_d    = idx_q;
    c_d      = c_q;
    zacc_d   = zacc_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
`ifdef ALU_SEQ_SIGNED_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op;
          idx_d   = '0;
          c_d     = 1'b0;
          zacc_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d[base +: N] = alu_s;
        zacc_d = zacc_q & alu_zero;
        idx_d  = idx_q + 1'b1;
        // Subtract codes report borrow; the next word wants "no borrow" as carry-in.
        unique case (op_q)
          OpAdd:   c_d = alu_cout;
          OpSub:   c_d = ~alu_cout;
          default: c_d = 1'b0;
        endcase
        if (last_word) begin
          carry_d = arith & alu_cout;
          zero_d  = zacc_q & alu_zero;
          idx_d   = '0;
          state_d = StDone;
`ifdef ALU_SEQ_SIGNED_EN
          unique case (op_q)
            OpAdd:   ovf_d = (sa == sb) && (ss != sa);
            OpSub:   ovf_d = (sa != sb) && (ss != sa);
            default: ovf_d = 1'b0;
          endcase
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= '0;
      c_q      <= 1'b0;
      zacc_q   <= 1'b1;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
`ifdef ALU_SEQ_SIGNED_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      zacc_q   <= zacc_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
`ifdef ALU_SEQ_SIGNED_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
`ifdef ALU_SEQ_SIGNED_EN
  assign ovf_flag   = ovf_q;
`else
  assign ovf_flag   = 1'b0;
`endif

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-word arithmetic sequencer. It is the initiator side of the N-bit ALU interface: it drives the ALU control code, operands and carry-in, and consumes the ALU sum, zero and carry-out.
- It chains a WORDS*N-bit add, subtract, AND or OR through one N-bit ALU, one word per cycle, least-significant word first.
- It sits between the datapath register file and the shared ALU instance and presents a start/busy/done handshake.

Parameters:
- N, 8, ALU word width.
- WORDS, 4, number of words per operand (must be >= 2).
- AC_N, 3, width of the ALU control code.
- CS_AD, 0, control code: add with carry-in.
- CS_SB, 1, control code: subtract with carry-in.
- CS_ADX, 2, control code: add ignoring carry-in.
- CS_SBX, 3, control code: subtract with forced carry-in of 1.
- CS_AN, 4, control code: bitwise AND.
- CS_OR, 5, control code: bitwise OR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- a_in  in  WORDS*N  operand A, captured on an accepted start.
- b_in  in  WORDS*N  operand B, captured on an accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  WORDS*N  final result, held until the next accepted start.
- carry_flag  out  1  final carry (ADD) or borrow (SUB); 0 for AND/OR.
- zero_flag  out  1  high when all result words are zero.
- ovf_flag  out  1  signed overflow (see Optional Feature).
- alu_cs  out  AC_N  ALU control code.
- alu_a  out  N  ALU operand A (current word).
- alu_b  out  N  ALU operand B (current word).
- alu_cin  out  1  ALU carry-in.
- alu_s  in  N  ALU result.
- alu_zero  in  1  ALU zero indication for the current word.
- alu_cout  in  1  ALU carry-out (for subtract codes this is the borrow).

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset state: state=IDLE, idx=0, busy=0, done=0, result=0, carry_flag=0, zero_flag=1, ovf_flag=0. Internal carry register c=0. Operand registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures a_in, b_in and op, clears idx, sets zero accumulator to 1, moves to RUN.
  - start=0: stay in IDLE.
- RUN, word idx:
  - alu_a = A[idx*N +: N], alu_b = B[idx*N +: N], alu_cin = c. All are combinational from registers.
  - alu_cs for idx=0: ADD→CS_ADX, SUB→CS_SBX.
  - alu_cs for idx>0: ADD→CS_AD, SUB→CS_SB.
  - alu_cs for AND/OR: CS_AN/CS_OR on every word.
- RUN, at each rising edge:
  - result word idx <= alu_s.
  - zero accumulator <= accumulator & alu_zero.
  - ADD: c <= alu_cout. SUB: c <= ~alu_cout (converts the ALU borrow into next-word carry-in). AND/OR: c <= 0.
  - idx <= idx+1.
  - At idx=WORDS-1: carry_flag <= alu_cout (0 for AND/OR), zero_flag <= final accumulator, go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge T; words processed at edges T+1..T+WORDS; done high during the cycle after edge T+WORDS; next start accepted at edge T+WORDS+2 at the earliest.
- Outputs while not in RUN: alu_cs=CS_ADX, alu_a/alu_b = word 0 of the operand registers, alu_cin=0.
- Start while busy: ignored, no queuing.
- op and operand inputs are don't-care outside the accepting edge.
- rst in any state returns to the reset state at that edge. An in-flight operation is abandoned with no done pulse.
- Wrap-around: ADD/SUB results are modulo 2^(WORDS*N); the overflow appears only in carry_flag.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_EN.
- Defined: at the DONE transition, ovf_flag is computed from the MSW sign bits a, b and s.
  - ADD: (a==b) && (s!=a).
  - SUB: (a!=b) && (s!=a).
  - AND/OR: 0.
  - Held with result; reset to 0.
- Undefined: ovf_flag is tied to 0 and no sign logic is built.

Test Plan (N=8, WORDS=4, bench models the ALU per the CS codes):
- ADD 0x000000FF + 0x00000001 → result 0x00000100, carry 0, zero 0; done exactly 5 cycles after the start edge; alu_cs sequence ADX,AD,AD,AD.
- ADD 0xFFFFFFFF + 0x00000001 → result 0x00000000, carry 1, zero 1.
- SUB 0x00000100 − 0x00000001 → 0x000000FF, carry 0. SUB 0x00000000 − 0x00000001 → 0xFFFFFFFF, carry 1. alu_cs sequence SBX,SB,SB,SB.
- AND 0xF0F0AAAA & 0xFF00FFFF → 0xF000AAAA; OR 0x0F000000 | 0x000000F0 → 0x0F0000F0; carry 0 for both.
- Start pulsed again in cycle 2 of RUN → ignored, single done, result unchanged. rst asserted in cycle 3 of RUN → IDLE next cycle, no done, result 0, zero_flag 1.
- With ALU_SEQ_SIGNED_EN: ADD 0x7FFFFFFF+1 → ovf 1; SUB 0x80000000−1 → ovf 1; ADD 1+1 → ovf 0. Without the macro, ovf stays 0 for all of these.
